// File: rtl/csa_pkg.sv
// ----------------------------------------------------------------------------
// csa_pkg
// Shared types and default widths for the CSA calculation scheduler.
//   slot_st_e  : per-instance slot state (FREE / RUNNING / DONE)
//   disp_st_e  : dispatch FSM state (D_IDLE / D_READ / D_START)
//   CSA_IN_W_DEF / CSA_OUT_W_DEF : default operand / result widths
// ----------------------------------------------------------------------------
package csa_pkg;

   localparam int CSA_IN_W_DEF  = 40;
   localparam int CSA_OUT_W_DEF = 48;

   typedef enum logic [1:0] {
      SLOT_FREE    = 2'd0,
      SLOT_RUNNING = 2'd1,
      SLOT_DONE    = 2'd2
   } slot_st_e;

   typedef enum logic [1:0] {
      D_IDLE  = 2'd0,
      D_READ  = 2'd1,
      D_START = 2'd2
   } disp_st_e;

endpackage

// File: rtl/csa_sched_slot.sv
// ----------------------------------------------------------------------------
// csa_sched_slot
// One scheduler slot: tracks a CSA instance through FREE -> RUNNING -> DONE
// and holds its captured result until the word is retired.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : dispatch into this slot (honoured only when FREE)
//   done        : instance completion pulse (honoured only when RUNNING)
//   done_data   : instance result, captured with done
//   retire      : result written out (honoured only when DONE)
//   st          : current slot state
//   result      : captured result register
// ----------------------------------------------------------------------------
module csa_sched_slot
   import csa_pkg::*;
#(
   parameter int OUT_W = CSA_OUT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             done,
   input  logic [OUT_W-1:0] done_data,
   input  logic             retire,
   output slot_st_e         st,
   output logic [OUT_W-1:0] result
);

   // Each event is gated by the state it belongs to, so stray done pulses
   // on FREE/DONE slots fall through without effect.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st     <= SLOT_FREE;
         result <= '0;
      end else begin
         case (st)
            SLOT_FREE:    if (start) st <= SLOT_RUNNING;
            SLOT_RUNNING: if (done) begin
                             result <= done_data;
                             st     <= SLOT_DONE;
                          end
            SLOT_DONE:    if (retire) st <= SLOT_FREE;
            default:      st <= SLOT_FREE;
         endcase
      end
   end

endmodule

// File: rtl/csa_calc_sched.sv
// ----------------------------------------------------------------------------
// csa_calc_sched
// Round-robin scheduler feeding words from an input FIFO to a pool of CSA
// calculation instances and writing results to an output FIFO in input order.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   sched_en            : allow new dispatches
//   csa_in_r_ready      : input FIFO non-empty
//   csa_in_ren          : input FIFO read strobe (data valid next cycle)
//   csa_in_rdata        : input FIFO read data
//   calc_start          : one-hot start pulse per instance
//   calc_in_data        : shared operand bus, valid with calc_start
//   calc_done           : per-instance completion pulse
//   calc_out_data       : per-instance result, slice i for instance i
//   csa_out_error_full  : output FIFO full
//   csa_out_wen         : output FIFO write strobe
//   csa_out_wdata       : output FIFO write data
//   sched_idle          : all slots FREE and dispatcher idle
// Optional (macro CSA_CALC_SCHED_STAT_EN):
//   stat_dispatch_cnt, stat_retire_cnt, stat_stall_cnt : 32-bit wrapping counters
// ----------------------------------------------------------------------------
module csa_calc_sched
   import csa_pkg::*;
#(
   parameter int CSA_CALC_INST_NUM  = 4,
   parameter int CSA_CALC_IN_WIDTH  = CSA_IN_W_DEF,
   parameter int CSA_CALC_OUT_WIDTH = CSA_OUT_W_DEF
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          sched_en,
   input  logic                                          csa_in_r_ready,
   output logic                                          csa_in_ren,
   input  logic [CSA_CALC_IN_WIDTH-1:0]                  csa_in_rdata,
   output logic [CSA_CALC_INST_NUM-1:0]                  calc_start,
   output logic [CSA_CALC_IN_WIDTH-1:0]                  calc_in_data,
   input  logic [CSA_CALC_INST_NUM-1:0]                  calc_done,
   input  logic [CSA_CALC_INST_NUM*CSA_CALC_OUT_WIDTH-1:0] calc_out_data,
   input  logic                                          csa_out_error_full,
   output logic                                          csa_out_wen,
   output logic [CSA_CALC_OUT_WIDTH-1:0]                 csa_out_wdata,
   output logic                                          sched_idle
`ifdef CSA_CALC_SCHED_STAT_EN
   ,
   output logic [31:0]                                   stat_dispatch_cnt,
   output logic [31:0]                                   stat_retire_cnt,
   output logic [31:0]                                   stat_stall_cnt
`endif
);

   localparam int N  = CSA_CALC_INST_NUM;
   localparam int OW = CSA_CALC_OUT_WIDTH;
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   disp_st_e              dstate;
   logic [PW-1:0]         disp_ptr;
   logic [PW-1:0]         ret_ptr;
   slot_st_e              slot_st [N];
   logic [N-1:0][OW-1:0]  slot_res;
   logic [N-1:0]          slot_start;
   logic [N-1:0]          slot_retire;
   logic                  retire_go;
   logic                  disp_go;

   // Slot state is registered, so a slot freed by a retire this cycle still
   // looks busy to the D_IDLE check; dispatch follows one cycle later.
   assign disp_go   = sched_en && csa_in_r_ready && (slot_st[disp_ptr] == SLOT_FREE);
   assign retire_go = (slot_st[ret_ptr] == SLOT_DONE) && !csa_out_error_full;

   assign slot_start  = (dstate == D_START) ? (N'(1) << disp_ptr) : '0;
   assign slot_retire = retire_go ? (N'(1) << ret_ptr) : '0;

   // Strobes decode straight from the state register: ren during D_READ,
   // start during D_START, when the FIFO data has arrived.
   assign csa_in_ren   = (dstate == D_READ);
   assign calc_start   = slot_start;
   assign calc_in_data = (dstate == D_START) ? csa_in_rdata : '0;

   generate
      for (genvar i = 0; i < N; i++) begin : g_slot
         csa_sched_slot #(.OUT_W(OW)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (slot_start[i]),
            .done      (calc_done[i]),
            .done_data (calc_out_data[i*OW +: OW]),
            .retire    (slot_retire[i]),
            .st        (slot_st[i]),
            .result    (slot_res[i])
         );
      end
   endgenerate

   // Dispatch FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dstate   <= D_IDLE;
         disp_ptr <= '0;
      end else begin
         case (dstate)
            D_IDLE:  if (disp_go) dstate <= D_READ;
            D_READ:  dstate <= D_START;
            D_START: begin
               dstate   <= D_IDLE;
               disp_ptr <= disp_ptr + 1'b1;  // N is a power of two: natural wrap
            end
            default: dstate <= D_IDLE;
         endcase
      end
   end

   // In-order retire: only the head slot may leave, so completion order
   // never affects output order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ret_ptr       <= '0;
         csa_out_wen   <= 1'b0;
         csa_out_wdata <= '0;
      end else begin
         csa_out_wen <= retire_go;
         if (retire_go) begin
            csa_out_wdata <= slot_res[ret_ptr];
            ret_ptr       <= ret_ptr + 1'b1;
         end
      end
   end

   always_comb begin
      sched_idle = (dstate == D_IDLE);
      for (int i = 0; i < N; i++)
         if (slot_st[i] != SLOT_FREE) sched_idle = 1'b0;
   end

`ifdef CSA_CALC_SCHED_STAT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_dispatch_cnt <= '0;
         stat_retire_cnt   <= '0;
         stat_stall_cnt    <= '0;
      end else begin
         if (dstate == D_START) stat_dispatch_cnt <= stat_dispatch_cnt + 32'd1;
         if (csa_out_wen)       stat_retire_cnt   <= stat_retire_cnt + 32'd1;
         if ((slot_st[ret_ptr] == SLOT_DONE) && csa_out_error_full)
            stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
   end
`endif

endmodule
